// File: rtl/gpu_pkg.sv
// Shared GPU definitions: sprite attribute layout, blank-tile marker and the
// sprite scheduler state encoding.
package gpu_pkg;

   localparam logic [15:0] SPRITE_BLANK = 16'hFFFF;

   localparam int TILE_LSB = 32;
   localparam int X_LSB    = 16;
   localparam int Y_LSB    = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } scan_state_t;

endpackage

// File: rtl/sprite_row_test.sv
// Combinational row coverage test: does a sprite starting at row y cover line?
// Modular distance makes sprites straddling the top edge (y near 16'hFFFF) work.
module sprite_row_test
   import gpu_pkg::*;
#(
   parameter int SPRITE_H = 16
) (
   input  logic [15:0] line,
   input  logic [15:0] y,
   input  logic [15:0] tile,
   output logic        hit,
   output logic [7:0]  yoff
);

   logic [15:0] d;

   always_comb begin
      d    = line - y;
      hit  = (tile != SPRITE_BLANK) && (d < 16'(SPRITE_H));
      yoff = d[7:0];
   end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Scans sprite attribute RAM for the next scanline and stages up to SLOTS hits
// in a shadow slot set, committed to the active slot outputs on swap.
//
// state | meaning
// IDLE  | waiting for start; shadow holds the last completed scan
// SCAN  | issuing one attribute read per cycle, evaluating returned entries
// DRAIN | evaluating the final returned entry, then done
module sprite_line_scheduler
   import gpu_pkg::*;
#(
   parameter int SPRITES  = 64,
   parameter int SLOTS    = 8,
   parameter int SPRITE_H = 16
) (
   input  logic                       gpu_clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [15:0]                next_line,
   input  logic                       swap,
   output logic                       attr_rd_en,
   output logic [$clog2(SPRITES)-1:0] attr_addr,
   input  logic [47:0]                attr_data,
   output logic                       busy,
   output logic                       done,
   output logic                       overflow,
   output logic                       late,
   output logic [SLOTS-1:0]           slot_valid,
   output logic [16*SLOTS-1:0]        slot_tile,
   output logic [16*SLOTS-1:0]        slot_x,
   output logic [8*SLOTS-1:0]         slot_yoff
);

   localparam int AW = $clog2(SPRITES);
   localparam int CW = $clog2(SLOTS + 1);
   localparam int SW = $clog2(SLOTS);

   scan_state_t state, state_next;

   logic [AW-1:0] idx;
   logic [CW-1:0] count;
   logic [15:0]   line;
   logic          pipe_v;
   logic          shadow_ready;
   logic          hit;
   logic [7:0]    yoff;

   logic [SLOTS-1:0] sh_valid;
   logic [15:0]      sh_tile [SLOTS];
   logic [15:0]      sh_x    [SLOTS];
   logic [7:0]       sh_yoff [SLOTS];
   logic [15:0]      act_tile [SLOTS];
   logic [15:0]      act_x    [SLOTS];
   logic [7:0]       act_yoff [SLOTS];

   sprite_row_test #(.SPRITE_H(SPRITE_H)) u_row_test (
      .line (line),
      .y    (attr_data[Y_LSB +: 16]),
      .tile (attr_data[TILE_LSB +: 16]),
      .hit  (hit),
      .yoff (yoff)
   );

   always_ff @(posedge gpu_clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (start) begin
         state_next = SCAN;
      end else begin
         case (state)
            SCAN:    if (idx == AW'(SPRITES - 1)) state_next = DRAIN;
            DRAIN:   state_next = IDLE;
            default: state_next = state;
         endcase
      end
   end

   assign attr_rd_en = (state == SCAN);
   assign attr_addr  = idx;
   assign busy       = (state != IDLE);

   always_ff @(posedge gpu_clk) begin
      if (!rst_n) begin
         idx          <= '0;
         count        <= '0;
         line         <= '0;
         pipe_v       <= 1'b0;
         shadow_ready <= 1'b0;
         done         <= 1'b0;
         overflow     <= 1'b0;
         late         <= 1'b0;
         sh_valid     <= '0;
         slot_valid   <= '0;
         for (int k = 0; k < SLOTS; k++) begin
            sh_tile[k]  <= '0;
            sh_x[k]     <= '0;
            sh_yoff[k]  <= '0;
            act_tile[k] <= '0;
            act_x[k]    <= '0;
            act_yoff[k] <= '0;
         end
      end else begin
         done   <= 1'b0;
         late   <= 1'b0;
         pipe_v <= (state == SCAN);
         if (state == SCAN) idx <= idx + 1'b1;

         if (pipe_v && hit) begin
            if (count < CW'(SLOTS)) begin
               sh_valid[count[SW-1:0]] <= 1'b1;
               sh_tile[count[SW-1:0]]  <= attr_data[TILE_LSB +: 16];
               sh_x[count[SW-1:0]]     <= attr_data[X_LSB +: 16];
               sh_yoff[count[SW-1:0]]  <= yoff;
               count                   <= count + 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end

         // Swap sees the pre-edge shadow; the DRAIN and start updates below win.
         if (swap) begin
            if (shadow_ready) begin
               slot_valid   <= sh_valid;
               act_tile     <= sh_tile;
               act_x        <= sh_x;
               act_yoff     <= sh_yoff;
               shadow_ready <= 1'b0;
            end else begin
               slot_valid <= '0;
               late       <= 1'b1;
            end
         end

         if (state == DRAIN) begin
            done         <= 1'b1;
            shadow_ready <= 1'b1;
         end

         if (start) begin
            idx          <= '0;
            count        <= '0;
            line         <= next_line;
            pipe_v       <= 1'b0;
            sh_valid     <= '0;
            shadow_ready <= 1'b0;
            overflow     <= 1'b0;
            done         <= 1'b0;
         end
      end
   end

   always_comb begin
      slot_tile = '0;
      slot_x    = '0;
      slot_yoff = '0;
      for (int k = 0; k < SLOTS; k++) begin
         slot_tile[16*k +: 16] = act_tile[k];
         slot_x[16*k +: 16]    = act_x[k];
         slot_yoff[8*k +: 8]   = act_yoff[k];
      end
   end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Self-checking bench for sprite_line_scheduler: attribute RAM model, scoreboard
// of expected slot sets, table-driven row tests and hand-written corner cases.
module tb_sprite_line_scheduler;

   localparam int SPRITES  = 64;
   localparam int SLOTS    = 8;
   localparam int SPRITE_H = 16;

   logic         gpu_clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         swap = 1'b0;
   logic [15:0]  next_line = '0;
   logic         attr_rd_en;
   logic [5:0]   attr_addr;
   logic [47:0]  attr_data = '0;
   logic         busy, done, overflow, late;
   logic [7:0]   slot_valid;
   logic [127:0] slot_tile, slot_x;
   logic [63:0]  slot_yoff;

   sprite_line_scheduler #(.SPRITES(SPRITES), .SLOTS(SLOTS), .SPRITE_H(SPRITE_H)) dut (
      .gpu_clk    (gpu_clk),
      .rst_n      (rst_n),
      .start      (start),
      .next_line  (next_line),
      .swap       (swap),
      .attr_rd_en (attr_rd_en),
      .attr_addr  (attr_addr),
      .attr_data  (attr_data),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .late       (late),
      .slot_valid (slot_valid),
      .slot_tile  (slot_tile),
      .slot_x     (slot_x),
      .slot_yoff  (slot_yoff)
   );

   always #5 gpu_clk = ~gpu_clk;

   logic [47:0] mem [SPRITES];

   always @(posedge gpu_clk) begin
      if (attr_rd_en) attr_data <= mem[attr_addr];
   end

   typedef struct {
      logic [7:0]   valid;
      logic [127:0] tile;
      logic [127:0] x;
      logic [63:0]  yoff;
      logic         ovf;
   } exp_t;

   typedef struct {
      logic [15:0] y;
      logic [15:0] line;
      logic        exp_hit;
      logic [7:0]  exp_yoff;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[6];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] ln);
      exp_t        e;
      int          n;
      logic [15:0] d;
      e.valid = '0; e.tile = '0; e.x = '0; e.yoff = '0; e.ovf = 1'b0;
      n = 0;
      for (int i = 0; i < SPRITES; i++) begin
         d = ln - mem[i][15:0];
         if (mem[i][47:32] != 16'hFFFF && d < 16'(SPRITE_H)) begin
            if (n < SLOTS) begin
               e.valid[n]        = 1'b1;
               e.tile[16*n +: 16] = mem[i][47:32];
               e.x[16*n +: 16]    = mem[i][31:16];
               e.yoff[8*n +: 8]   = d[7:0];
               n++;
            end else begin
               e.ovf = 1'b1;
            end
         end
      end
      return e;
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < SPRITES; i++) mem[i] = {16'hFFFF, 16'h0000, 16'h0000};
   endtask

   // Returns at the negedge of cycle T+1, T being the edge that samples start.
   task automatic pulse_start(input logic [15:0] ln);
      @(negedge gpu_clk);
      start = 1'b1;
      next_line = ln;
      @(negedge gpu_clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, output int cyc);
      cyc = 1;
      while (done !== 1'b1 && cyc < 300) begin
         @(negedge gpu_clk);
         cyc++;
      end
      check({name, " done latency"}, 128'(cyc), 128'(66));
   endtask

   task automatic commit_and_check(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", name);
         return;
      end
      e = sb.pop_front();
      swap = 1'b1;
      @(negedge gpu_clk);
      swap = 1'b0;
      check({name, " late"}, 128'(late), 128'(0));
      check({name, " slot_valid"}, 128'(slot_valid), 128'(e.valid));
      for (int k = 0; k < SLOTS; k++) begin
         if (e.valid[k]) begin
            check($sformatf("%s tile%0d", name, k), 128'(slot_tile[16*k +: 16]), 128'(e.tile[16*k +: 16]));
            check($sformatf("%s x%0d", name, k), 128'(slot_x[16*k +: 16]), 128'(e.x[16*k +: 16]));
            check($sformatf("%s yoff%0d", name, k), 128'(slot_yoff[8*k +: 8]), 128'(e.yoff[8*k +: 8]));
         end
      end
   endtask

   initial begin
      int cyc;
      int ndone;

      tbl[0] = '{y: 16'd100,   line: 16'd107, exp_hit: 1'b1, exp_yoff: 8'd7};
      tbl[1] = '{y: 16'd100,   line: 16'd99,  exp_hit: 1'b0, exp_yoff: 8'd0};
      tbl[2] = '{y: 16'd100,   line: 16'd116, exp_hit: 1'b0, exp_yoff: 8'd0};
      tbl[3] = '{y: 16'd100,   line: 16'd115, exp_hit: 1'b1, exp_yoff: 8'd15};
      tbl[4] = '{y: 16'd100,   line: 16'd100, exp_hit: 1'b1, exp_yoff: 8'd0};
      tbl[5] = '{y: 16'hFFF8,  line: 16'd4,   exp_hit: 1'b1, exp_yoff: 8'd12};

      clear_mem();
      repeat (3) @(negedge gpu_clk);
      check("reset busy", 128'(busy), 128'(0));
      check("reset outputs", {done, overflow, late, attr_rd_en, attr_addr, slot_valid},
            128'(0));
      check("reset slot buses", slot_tile | slot_x | 128'(slot_yoff), 128'(0));
      rst_n = 1'b1;
      @(negedge gpu_clk);
      check("idle busy", 128'(busy), 128'(0));

      // swap with no completed scan
      swap = 1'b1;
      @(negedge gpu_clk);
      swap = 1'b0;
      check("early swap late", 128'(late), 128'(1));
      check("early swap valid", 128'(slot_valid), 128'(0));
      @(negedge gpu_clk);
      check("late single cycle", 128'(late), 128'(0));

      for (int t = 0; t < 6; t++) begin
         clear_mem();
         mem[3] = {16'h0012, 16'd40, tbl[t].y};
         sb.push_back(model(tbl[t].line));
         pulse_start(tbl[t].line);
         check($sformatf("row%0d first read", t), {busy, attr_rd_en, 2'b00, attr_addr}, {2'b11, 8'h00});
         wait_done($sformatf("row%0d", t), cyc);
         commit_and_check($sformatf("row%0d", t));
         check($sformatf("row%0d hit", t), 128'(slot_valid), 128'(tbl[t].exp_hit));
         if (tbl[t].exp_hit) begin
            check($sformatf("row%0d slot0", t), {slot_tile[15:0], slot_x[15:0], slot_yoff[7:0]},
                  {16'h0012, 16'd40, tbl[t].exp_yoff});
         end
      end

      // overflow: ten hits, eight slots
      clear_mem();
      for (int i = 0; i < 10; i++) mem[i] = {16'(i + 1), 16'(i * 8), 16'd50};
      sb.push_back(model(16'd50));
      pulse_start(16'd50);
      wait_done("ovf", cyc);
      check("ovf flag", 128'(overflow), 128'(1));
      commit_and_check("ovf");
      for (int k = 0; k < SLOTS; k++)
         check($sformatf("ovf tile order %0d", k), 128'(slot_tile[16*k +: 16]), 128'(k + 1));
      sb.push_back(model(16'd50));
      pulse_start(16'd50);
      check("ovf cleared by start", 128'(overflow), 128'(0));
      wait_done("ovf2", cyc);
      check("ovf2 flag", 128'(overflow), 128'(1));
      commit_and_check("ovf2");

      // restart mid-scan
      clear_mem();
      mem[0] = {16'h0005, 16'd11, 16'd195};
      mem[1] = {16'h0006, 16'd22, 16'd5};
      ndone = 0;
      pulse_start(16'd200);
      for (int c = 1; c < 20; c++) begin
         if (done === 1'b1) ndone++;
         @(negedge gpu_clk);
      end
      start = 1'b1;
      next_line = 16'd10;
      sb.push_back(model(16'd10));
      @(negedge gpu_clk);
      start = 1'b0;
      wait_done("restart", cyc);
      check("restart early dones", 128'(ndone), 128'(0));
      commit_and_check("restart");
      for (int c = 0; c < 10; c++) begin
         if (done === 1'b1) ndone++;
         @(negedge gpu_clk);
      end
      check("restart extra dones", 128'(ndone), 128'(0));

      // swap landing on the DRAIN edge
      sb.push_back(model(16'd10));
      pulse_start(16'd10);
      repeat (64) @(negedge gpu_clk);
      check("drain cycle", {busy, done}, 128'(2'b10));
      swap = 1'b1;
      @(negedge gpu_clk);
      swap = 1'b0;
      check("drain swap done", 128'(done), 128'(1));
      check("drain swap late", 128'(late), 128'(1));
      check("drain swap cleared", 128'(slot_valid), 128'(0));
      commit_and_check("after drain");

      // reset mid-scan discards the partial shadow
      pulse_start(16'd10);
      repeat (30) @(negedge gpu_clk);
      rst_n = 1'b0;
      repeat (2) @(negedge gpu_clk);
      rst_n = 1'b1;
      check("midscan reset busy", {busy, attr_rd_en, slot_valid}, 128'(0));
      swap = 1'b1;
      @(negedge gpu_clk);
      swap = 1'b0;
      check("midscan reset swap late", {late, slot_valid}, {1'b1, 8'h00});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
